// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
// Opcode encodings match the external ALU.
package alu_arb_pkg;

  localparam int NREQ   = 2;
  localparam int OPND_W = 8;
  localparam int RES_W  = 16;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_NOT  = 3'b011,
    OP_XOR  = 3'b100,
    OP_ABS  = 3'b101,
    OP_SUBH = 3'b110
  } alu_op_e;

  typedef struct packed {
    logic v;
    logic id;
  } tag_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the arbiter.
// slave = arbiter side, master = environment side.
interface alu_arbiter_if;
  import alu_arb_pkg::*;

  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [NREQ*OPND_W-1:0] req_a_i;
  logic [NREQ*OPND_W-1:0] req_b_i;
  logic [NREQ*OP_W-1:0]   req_inst_i;
  logic [NREQ-1:0]        rsp_valid_o;
  logic [NREQ-1:0]        rsp_ready_i;
  logic [NREQ*RES_W-1:0]  rsp_data_o;
  logic [OPND_W-1:0]      alu_a_o;
  logic [OPND_W-1:0]      alu_b_o;
  logic [OP_W-1:0]        alu_inst_o;
  logic [RES_W-1:0]       alu_data_i;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i,
    input  req_inst_i, rsp_ready_i, alu_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o,
    output alu_a_o, alu_b_o, alu_inst_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i,
    output req_inst_i, rsp_ready_i, alu_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o,
    input  alu_a_o, alu_b_o, alu_inst_o
  );

endinterface

// File: rtl/alu_arb_fifo.sv
// Per-requester result FIFO with occupancy count.
// Push and pop in one cycle both take effect, also when full.
module alu_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_p_i,
  input  logic             reset_p_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] inc(logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data_i;
      wr_d        = inc(wr_q);
    end
    if (do_pop) rd_d = inc(rd_q);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_p_i) begin
    mem_q <= mem_d;
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a pipelined ALU with result FIFOs.
// Define ALU_ARB_RR_EN for round-robin; default is fixed priority to req 0.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 2
) (
  input logic          clk_p_i,
  input logic          reset_p_i,
  alu_arbiter_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(FIFO_DEPTH + ALU_LAT + 1);

  tag_t            tag_q [ALU_LAT];
  tag_t            tag_d [ALU_LAT];
  tag_t            tag_out;
  logic [CW-1:0]   cnt  [NREQ];
  logic [SW-1:0]   infl [NREQ];
  logic [RES_W-1:0] head [NREQ];
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] push;
  logic [NREQ-1:0] fvalid;

  // Credit covers buffered results plus those still in the ALU.
  always_comb begin
    for (int n = 0; n < NREQ; n++) begin
      infl[n] = '0;
      for (int s = 0; s < ALU_LAT; s++)
        if (tag_q[s].v && (tag_q[s].id == 1'(n)))
          infl[n] = infl[n] + SW'(1);
      elig[n] = bus.req_valid_i[n] && !reset_p_i &&
                ((SW'(cnt[n]) + infl[n]) < SW'(FIFO_DEPTH));
    end
  end

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    gnt[0] = elig[0] && (!elig[1] || last_q);
    gnt[1] = elig[1] && (!elig[0] || !last_q);
    last_d = (|gnt) ? gnt[1] : last_q;
  end

  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) last_q <= 1'b1;
    else           last_q <= last_d;
  end
`else
  always_comb begin
    gnt[0] = elig[0];
    gnt[1] = elig[1] && !elig[0];
  end
`endif

  assign bus.req_ready_o = gnt;

  always_comb begin
    bus.alu_a_o    = '0;
    bus.alu_b_o    = '0;
    bus.alu_inst_o = OP_ADD;
    unique case (1'b1)
      gnt[0]: begin
        bus.alu_a_o    = bus.req_a_i[0 +: OPND_W];
        bus.alu_b_o    = bus.req_b_i[0 +: OPND_W];
        bus.alu_inst_o = bus.req_inst_i[0 +: OP_W];
      end
      gnt[1]: begin
        bus.alu_a_o    = bus.req_a_i[OPND_W +: OPND_W];
        bus.alu_b_o    = bus.req_b_i[OPND_W +: OPND_W];
        bus.alu_inst_o = bus.req_inst_i[OP_W +: OP_W];
      end
      default: ;
    endcase
  end

  always_comb begin
    tag_d[0] = '{v: |gnt, id: gnt[1]};
    for (int s = 1; s < ALU_LAT; s++)
      tag_d[s] = tag_q[s-1];
  end

  // Clearing the tags on reset drops results of older issues.
  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      for (int s = 0; s < ALU_LAT; s++)
        tag_q[s] <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_out = tag_q[ALU_LAT-1];

  always_comb begin
    for (int n = 0; n < NREQ; n++)
      push[n] = tag_out.v && (tag_out.id == 1'(n));
  end

  for (genvar n = 0; n < NREQ; n++) begin : g_fifo
    alu_arb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RES_W),
      .CW    (CW)
    ) u_fifo (
      .clk_p_i     (clk_p_i),
      .reset_p_i   (reset_p_i),
      .push_i      (push[n]),
      .push_data_i (bus.alu_data_i),
      .pop_i       (bus.rsp_ready_i[n]),
      .valid_o     (fvalid[n]),
      .data_o      (head[n]),
      .count_o     (cnt[n])
    );
  end

  assign bus.rsp_valid_o = fvalid;
  assign bus.rsp_data_o  = {head[1], head[0]};

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set result-buffer entries per requester (min 2).
REQ-002 Parameter ALU_LAT, default 2, SHALL set cycles from operand issue to valid alu_data_i.
REQ-003 clk_p_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_p_i  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req_valid_i  input  2  SHALL flag a pending operation, bit n = requester n.
REQ-006 req_ready_o  output  2  SHALL flag acceptance; issue when valid and ready in the same cycle.
REQ-007 req_a_i  input  16  SHALL carry operand A, [8n+7:8n] for requester n.
REQ-008 req_b_i  input  16  SHALL carry operand B, same packing.
REQ-009 req_inst_i  input  6  SHALL carry the 3-bit opcode, [3n+2:3n].
REQ-010 rsp_valid_o  output  2  SHALL flag a buffered result for requester n.
REQ-011 rsp_ready_i  input  2  SHALL pop the result head when high with rsp_valid_o.
REQ-012 rsp_data_o  output  32  SHALL carry the 16-bit result head, [16n+15:16n].
REQ-013 alu_a_o / alu_b_o  output  8 each  SHALL drive ALU operands.
REQ-014 alu_inst_o  output  3  SHALL drive the ALU opcode.
REQ-015 alu_data_i  input  16  SHALL receive the ALU result, ALU_LAT cycles after issue.

Function
REQ-016 At most one requester SHALL be granted per cycle; req_ready_o SHALL be one-hot or zero.
REQ-017 req_ready_o[n] SHALL be high only if granted and fifo_count[n] + inflight[n] < FIFO_DEPTH, counts taken at the start of the cycle (same-cycle pops not credited).
REQ-018 Issue in cycle N SHALL drive the granted operands and opcode on alu_* in cycle N combinationally; with no issue alu_a_o=0, alu_b_o=0, alu_inst_o=3'b000.
REQ-019 A tag pipeline of ALU_LAT stages {valid, id} SHALL track issues; alu_data_i in cycle N+ALU_LAT SHALL be written into FIFO[id] at the end of that cycle, rsp_valid_o[id] high from N+ALU_LAT+1.
REQ-020 Results SHALL return in issue order per requester; no reordering, dropping or duplication.
REQ-021 Back-to-back issues SHALL be accepted every cycle when credit allows (throughput 1/cycle).
REQ-022 Simultaneous push and pop on the same FIFO SHALL both take effect, count unchanged, including at full.
REQ-023 rsp_data_o lanes SHALL show the FIFO head; an empty lane SHALL read 0.
REQ-024 rsp_valid_o/rsp_ready_i SHALL not affect the other requester's grants.

Reset
REQ-025 In any cycle with reset_p_i high: req_ready_o=0, no issue, alu_* as idle (REQ-018).
REQ-026 After reset: rsp_valid_o=0, rsp_data_o=0, FIFO counts 0, tag pipeline cleared, RR pointer favours requester 0.
REQ-027 ALU results from issues made before reset SHALL be discarded, never buffered.

Configuration
REQ-028 With ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: when both eligible, grant the one not granted last; pointer updates only on issue.
REQ-029 Without ALU_ARB_RR_EN, requester 0 SHALL have fixed priority whenever eligible.

Structure
REQ-030 Package alu_arb_pkg SHALL hold opcode constants (ADD 000, SUB 001 = B-A, MUL 010, NOT 011, XOR 100, ABS 101, SUBH 110 = (B-A)>>1) and width constants (operand 8, result 16, opcode 3).
REQ-031 Sub-module alu_arb_fifo (per-requester FIFO with count output) SHALL be instantiated twice.

Verification
REQ-032 Req0 ADD a=3 b=4 at cycle 0, ALU model latency 2 -> alu_* = 3/4/000 cycle 0; rsp_valid_o[0] cycle 3, data 7.
REQ-033 Both streaming SUB a=3 b=10, rsp_ready_i=2'b11 -> with macro grants alternate 0,1,0,1, all results 7; without macro all grants to 0.
REQ-034 rsp_ready_i[1]=0, req1 streaming MUL a=5 b=6 -> exactly 4 issues accepted, then req_ready_o[1]=0; req0 keeps issuing every cycle.
REQ-035 Req0 full (4 entries), pop and new result arrive same cycle -> count stays 4, order preserved, no loss.
REQ-036 Issue XOR a=8'h0F b=8'hF0 in cycle 0, reset in cycle 1 -> rsp_valid_o stays 0, FIFOs empty, next issue gets fresh result 16'h00FF.
